// File: rtl/coin_debounce_encoder_if.sv
// Coin sensor / coin code bundle between the sensor conditioner and its environment.
interface coin_debounce_encoder_if;
    logic       Coin_half;
    logic       Coin_one;
    logic       Enable;
    logic [1:0] D_out;
    logic [1:0] Jam;

    modport master (
        output Coin_half,
        output Coin_one,
        output Enable,
        input  D_out,
        input  Jam
    );

    modport slave (
        input  Coin_half,
        input  Coin_one,
        input  Enable,
        output D_out,
        output Jam
    );
endinterface

// File: rtl/coin_debounce_encoder.sv
// Coin sensor conditioner: two independent channels (bit 0 = half, bit 1 = one),
// each with a 2-FF synchroniser, a debouncer, a reset-arming guard and a jam detector.
// D_out carries a one-cycle coin code straight into the vend FSM's D_in.
module coin_debounce_encoder #(
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned JAM_CYCLES = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    coin_debounce_encoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_DB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LP_JAM      = CNT_W'(JAM_CYCLES);
    localparam logic [CNT_W-1:0] LP_JAM_LAST = CNT_W'(JAM_CYCLES - 1);

    logic [1:0]       w_raw;
    logic [1:0]       w_accept;
    logic [1:0]       w_rise;
    logic [1:0]       w_fall;

    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_stable;
    logic [1:0]       r_armed;
    logic [1:0]       r_dout;
    logic [1:0]       r_jam;
    logic [CNT_W-1:0] r_dcnt [2];
    logic [CNT_W-1:0] r_acnt [2];
    logic [CNT_W-1:0] r_jcnt [2];

    assign w_raw     = {bus.Coin_one, bus.Coin_half};
    assign bus.D_out = r_dout;
    assign bus.Jam   = r_jam;

    // Decode debounce acceptance and direction of the accepted transition
    always_comb begin
        w_accept = '0;
        w_rise   = '0;
        w_fall   = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            w_accept[c] = (r_s2[c] != r_stable[c]) && (r_dcnt[c] == LP_DB_LAST);
            w_rise[c]   = w_accept[c] && !r_stable[c];
            w_fall[c]   = w_accept[c] &&  r_stable[c];
        end
    end

    // Two-flop synchroniser for the asynchronous sensors
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Debouncer: a new level must persist DEBOUNCE edges; any agreeing edge restarts the count
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stable <= '0;
            for (int unsigned c = 0; c < 2; c++) r_dcnt[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                if (r_s2[c] != r_stable[c]) begin
                    if (w_accept[c]) begin
                        r_stable[c] <= r_s2[c];
                        r_dcnt[c]   <= '0;
                    end else begin
                        r_dcnt[c]   <= r_dcnt[c] + 1'b1;
                    end
                end else begin
                    r_dcnt[c] <= '0;
                end
            end
        end
    end

    // Arming guard: the synchroniser resets to 0, so a bare "stable==0" would arm a sensor
    // held high through reset. Arming instead waits for the synced level to be seen low
    // for DEBOUNCE consecutive edges while the debounced level is low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_armed <= '0;
            for (int unsigned c = 0; c < 2; c++) r_acnt[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                if (!r_armed[c]) begin
                    if (!r_stable[c] && !r_s2[c]) begin
                        if (r_acnt[c] == LP_DB_LAST) r_armed[c] <= 1'b1;
                        else                         r_acnt[c]  <= r_acnt[c] + 1'b1;
                    end else begin
                        r_acnt[c] <= '0;
                    end
                end
            end
        end
    end

    // One-cycle coin code on an armed, enabled debounced rise
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_rise & r_armed & {2{bus.Enable}};
        end
    end

    // Jam detector: saturating count of stable-high edges, cleared when the level drops
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_jam <= '0;
            for (int unsigned c = 0; c < 2; c++) r_jcnt[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                if (!r_stable[c] || w_fall[c]) begin
                    r_jcnt[c] <= '0;
                    r_jam[c]  <= 1'b0;
                end else begin
                    if (r_jcnt[c] != LP_JAM) r_jcnt[c] <= r_jcnt[c] + 1'b1;
                    r_jam[c] <= (r_jcnt[c] >= LP_JAM_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_coin_debounce_encoder.sv
// Bench for coin_debounce_encoder: directed scenarios followed by a randomized phase,
// all checked every cycle against a history-based reference model.
module tb_coin_debounce_encoder;

    localparam int D = 4;
    localparam int J = 64;
    localparam int N = 8192;

    logic Clk = 1'b0;
    logic Reset;

    int checks = 0;
    int errors = 0;

    coin_debounce_encoder_if bus ();

    coin_debounce_encoder #(
        .DEBOUNCE   (D),
        .JAM_CYCLES (J),
        .CNT_W      (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference model: per-channel raw-sample history and debounced-level history,
    // indexed by edge number since the last reset release.
    bit         raw_h [2][N];
    bit         st_h  [2][N];
    int         k;
    int         last_acc [2];
    bit         stable_m [2];
    bit         armed_m  [2];
    logic [1:0] exp_d;
    logic [1:0] exp_j;

    int tcyc;
    int cnt01, cnt10, cnt11;
    int first_pulse;
    bit jam_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, tcyc);
        end
    endtask

    // Synced level seen at edge i is the raw level sampled two edges earlier
    function automatic bit s2_at(input int c, input int i);
        if (i >= 2) return raw_h[c][i-2];
        return 1'b0;
    endfunction

    task automatic model_reset();
        k = 0;
        for (int c = 0; c < 2; c++) begin
            last_acc[c] = -1;
            stable_m[c] = 1'b0;
            armed_m[c]  = 1'b0;
        end
        exp_d = 2'b00;
        exp_j = 2'b00;
    endtask

    task automatic model_edge(input bit h, input bit o, input bit en);
        bit raw [2];
        bit acc, rise, fall, ok;
        int n, j;
        raw[0] = h;
        raw[1] = o;
        if (k >= N) begin
            $display("FAIL model_history_overflow");
            $fatal(1, "model history exhausted");
        end
        for (int c = 0; c < 2; c++) begin
            raw_h[c][k] = raw[c];
            st_h[c][k]  = stable_m[c];
            // accepted when each of the last D edges since the previous acceptance disagreed
            acc = (k - last_acc[c]) >= D;
            if (acc)
                for (int i = 0; i < D; i++)
                    if (s2_at(c, k - i) == stable_m[c]) acc = 1'b0;
            rise = acc && !stable_m[c];
            fall = acc &&  stable_m[c];
            exp_d[c] = rise && armed_m[c] && en;
            // armed after D consecutive edges with both synced and debounced level low
            if (!armed_m[c] && k >= D - 1) begin
                ok = 1'b1;
                for (int i = 0; i < D; i++)
                    if (st_h[c][k-i] || s2_at(c, k - i)) ok = 1'b0;
                armed_m[c] = ok;
            end
            // jammed once J consecutive stable-high edges end here
            if (stable_m[c] && !fall) begin
                n = 0;
                j = k;
                while (j >= 0 && n < J && st_h[c][j]) begin
                    n++;
                    j--;
                end
                exp_j[c] = (n >= J);
            end else begin
                exp_j[c] = 1'b0;
            end
            if (acc) begin
                stable_m[c] = !stable_m[c];
                last_acc[c] = k;
            end
        end
        k++;
    endtask

    // One clock: entered and left at a falling edge
    task automatic cyc(input bit h, input bit o, input bit en);
        bus.Coin_half = h;
        bus.Coin_one  = o;
        bus.Enable    = en;
        @(posedge Clk);
        if (!Reset) model_edge(h, o, en);
        #1;
        tcyc++;
        if (!Reset) begin
            chk("d_out", {30'd0, bus.D_out}, {30'd0, exp_d});
            chk("jam",   {30'd0, bus.Jam},   {30'd0, exp_j});
        end
        if (bus.D_out == 2'b01) cnt01++;
        if (bus.D_out == 2'b10) cnt10++;
        if (bus.D_out == 2'b11) cnt11++;
        if (bus.D_out != 2'b00 && first_pulse < 0) first_pulse = tcyc;
        if (bus.Jam != 2'b00) jam_seen = 1'b1;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic clr_counts();
        cnt01 = 0;
        cnt10 = 0;
        cnt11 = 0;
        first_pulse = -1;
        jam_seen = 1'b0;
    endtask

    // Asserted mid-cycle: outputs must clear without waiting for a clock
    task automatic do_reset(input int hold);
        #1;
        Reset = 1'b1;
        #1;
        chk("reset_d_out", {30'd0, bus.D_out}, 32'd0);
        chk("reset_jam",   {30'd0, bus.Jam},   32'd0);
        model_reset();
        for (int i = 0; i < hold; i++) cyc(bus.Coin_half, bus.Coin_one, bus.Enable);
        Reset = 1'b0;
    endtask

    int start;
    int run_left [2];
    bit lvl [2];
    bit en_r;

    initial begin
        Reset = 1'b1;
        bus.Coin_half = 1'b0;
        bus.Coin_one  = 1'b0;
        bus.Enable    = 1'b1;
        tcyc = 0;
        clr_counts();
        model_reset();
        @(negedge Clk);
        do_reset(2);
        idle(8);

        // 1: half coin held 10 cycles -> one 01 pulse after edge 5, none on release
        clr_counts();
        start = tcyc;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);
        idle(12);
        chk("s1_cnt01", cnt01, 1);
        chk("s1_cnt_other", cnt10 + cnt11, 0);
        chk("s1_latency", first_pulse - start - 1, D + 1);

        // 2: 3-cycle glitch ignored, 4-cycle pulse accepted
        clr_counts();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        idle(10);
        chk("s2_glitch", cnt10 + cnt01 + cnt11, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        idle(10);
        chk("s2_cnt10", cnt10, 1);

        // 3: simultaneous rise -> single 11; one-cycle offset -> 01 then 10
        clr_counts();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1);
        idle(12);
        chk("s3_cnt11", cnt11, 1);
        chk("s3_cnt_split", cnt01 + cnt10, 0);
        clr_counts();
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1);
        idle(12);
        chk("s3_offset_cnt01", cnt01, 1);
        chk("s3_offset_cnt10", cnt10, 1);
        chk("s3_offset_cnt11", cnt11, 0);

        // 4: half held 70 cycles -> single credit, jam raised then cleared on release
        clr_counts();
        for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("s4_jam_now", {30'd0, bus.Jam}, 32'd1);
        idle(12);
        chk("s4_cnt01", cnt01, 1);
        chk("s4_jam_seen", {31'd0, jam_seen}, 32'd1);
        chk("s4_jam_clear", {30'd0, bus.Jam}, 32'd0);

        // 5: rise while disabled is lost, enabling afterwards does not replay it
        clr_counts();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1);
        idle(10);
        chk("s5_lost", cnt10 + cnt01 + cnt11, 0);

        // 6: sensor held across reset never credits; release and re-insert does
        clr_counts();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        do_reset(2);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);
        chk("s6_held", cnt10 + cnt01 + cnt11, 0);
        idle(12);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);
        idle(10);
        chk("s6_reinsert", cnt10, 1);

        // Randomized phase: random run lengths, enable toggling, occasional resets
        for (int c = 0; c < 2; c++) begin
            run_left[c] = 0;
            lvl[c] = 1'b0;
        end
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (run_left[c] == 0) begin
                    lvl[c] = $urandom_range(1, 0);
                    run_left[c] = ($urandom_range(40, 0) == 0) ? 80 : $urandom_range(8, 1);
                end
                run_left[c]--;
            end
            if ($urandom_range(9, 0) == 0) en_r = ~en_r;
            if ($urandom_range(399, 0) == 0) do_reset(2);
            cyc(lvl[0], lvl[1], en_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
